// File: rtl/irr_param_if.sv
// Request-register bus between PIC control logic and the IRR.
// Control drives requests/controls; the IRR returns latched vectors.
interface irr_param_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] ir_in;
    logic               level_or_edge_flag;
    logic [NUM_IRQ-1:0] mask;
    logic               freeze;
    logic [NUM_IRQ-1:0] clear_interrupt_request;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] irr_masked;
    logic               int_pending;

    modport master (
        output ir_in,
        output level_or_edge_flag,
        output mask,
        output freeze,
        output clear_interrupt_request,
        input  irr,
        input  irr_masked,
        input  int_pending
    );

    modport slave (
        input  ir_in,
        input  level_or_edge_flag,
        input  mask,
        input  freeze,
        input  clear_interrupt_request,
        output irr,
        output irr_masked,
        output int_pending
    );
endinterface

// File: rtl/irr_param.sv
// Interrupt Request Register for an 8259-style PIC.
// Synchronises, latches (edge/level) and freezes requests during INTA.
module irr_param #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        reset,
    irr_param_if.slave bus
);
    logic [NUM_IRQ-1:0] s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s = bus.ir_in;
        end else begin : g_sync
            logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
            logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = bus.ir_in;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    if (reset) begin
                        sync_q[k] <= '0;
                    end else begin
                        sync_q[k] <= sync_d[k];
                    end
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] irr_masked_q, irr_masked_d;
    logic               int_pending_q, int_pending_d;
    logic [NUM_IRQ-1:0] ir_prev_q, ir_prev_d;
    logic [NUM_IRQ-1:0] edge_armed_q, edge_armed_d;
    logic               ltim_q, ltim_d;
    logic               frz_prev_q, frz_prev_d;

    logic               unfreeze;
    logic               mode_chg;
    logic [NUM_IRQ-1:0] edge_set;

    always_comb begin
        unfreeze = frz_prev_q & ~bus.freeze;
        mode_chg = bus.level_or_edge_flag ^ ltim_q;
        // Leaving freeze, a still-high armed line counts as an edge.
        edge_set = s & edge_armed_q
                 & (~ir_prev_q | {NUM_IRQ{unfreeze}});

        irr_d        = irr_q;
        edge_armed_d = edge_armed_q | ~s;

        if (mode_chg) begin
            irr_d        = '0;
            edge_armed_d = ~s;
        end else if (ltim_q) begin
            if (!bus.freeze) begin
                irr_d = s;
            end
            irr_d = irr_d & ~bus.clear_interrupt_request;
        end else begin
            if (!bus.freeze) begin
                irr_d        = edge_set | (irr_q & s);
                edge_armed_d = (edge_armed_q & ~edge_set) | ~s;
            end
            irr_d = irr_d & ~bus.clear_interrupt_request;
        end

        ir_prev_d     = s;
        ltim_d        = bus.level_or_edge_flag;
        frz_prev_d    = bus.freeze;
        irr_masked_d  = irr_d & ~bus.mask;
        int_pending_d = |irr_masked_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irr_q         <= '0;
            irr_masked_q  <= '0;
            int_pending_q <= 1'b0;
            ir_prev_q     <= '0;
            edge_armed_q  <= '1;
            // Track the live mode so leaving reset is not a mode change.
            ltim_q        <= bus.level_or_edge_flag;
            frz_prev_q    <= 1'b0;
        end else begin
            irr_q         <= irr_d;
            irr_masked_q  <= irr_masked_d;
            int_pending_q <= int_pending_d;
            ir_prev_q     <= ir_prev_d;
            edge_armed_q  <= edge_armed_d;
            ltim_q        <= ltim_d;
            frz_prev_q    <= frz_prev_d;
        end
    end

    assign bus.irr         = irr_q;
    assign bus.irr_masked  = irr_masked_q;
    assign bus.int_pending = int_pending_q;
endmodule
